// File: rtl/alu_cmd_sequencer.sv
// Byte-stream command sequencer: collects operand A, operand B and an opcode, drives the external ALU, returns the result.
// Define ALU_OPCODE_CHECK_EN to reject unsupported opcodes with a one-cycle o_error pulse.
module alu_cmd_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int NB_TIMEOUT     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    output logic [NB_DATA-1:0] o_alu_data_a,
    output logic [NB_DATA-1:0] o_alu_data_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_error
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND
    } state_t;

    localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
    localparam logic [NB_TIMEOUT-1:0] CNT_MAX      = '1;

    state_t                state;
    logic [NB_TIMEOUT-1:0] idle_cnt;
    logic                  rx_fire;
    logic                  timeout_hit;

    assign rx_fire     = i_rx_valid & o_rx_ready;
    assign timeout_hit = (idle_cnt == TIMEOUT_LAST);

`ifdef ALU_OPCODE_CHECK_EN
    function automatic logic is_legal(input logic [NB_OP-1:0] op);
        return op inside {NB_OP'(32), NB_OP'(34), NB_OP'(36), NB_OP'(37),
                          NB_OP'(38), NB_OP'(2), NB_OP'(3), NB_OP'(39)};
    endfunction
`else
    assign o_error = 1'b0;
`endif

    // Every output is registered, so each transition also sets the ready/busy flags of the state it enters.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            // NOTE: operand/opcode/result registers are cleared here too, so a reset mid-command leaves nothing stale.
            state        <= WAIT_A;
            idle_cnt     <= '0;
            o_rx_ready   <= 1'b0;
            o_busy       <= 1'b0;
            o_alu_data_a <= '0;
            o_alu_data_b <= '0;
            o_alu_op     <= '0;
            o_tx_data    <= '0;
            o_tx_valid   <= 1'b0;
`ifdef ALU_OPCODE_CHECK_EN
            o_error      <= 1'b0;
`endif
        end else begin
`ifdef ALU_OPCODE_CHECK_EN
            o_error <= 1'b0;
`endif
            case (state)
                WAIT_A: begin
                    // NOTE: non-blocking assignments everywhere; later ones in this block override earlier ones.
                    o_rx_ready <= 1'b1;
                    o_busy     <= 1'b0;
                    idle_cnt   <= '0;
                    if (rx_fire) begin
                        o_alu_data_a <= i_rx_data;
                        o_busy       <= 1'b1;
                        state        <= WAIT_B;
                    end
                end
                WAIT_B, WAIT_OP: begin
                    if (rx_fire) begin
                        idle_cnt <= '0;
                        if (state == WAIT_B) begin
                            o_alu_data_b <= i_rx_data;
                            state        <= WAIT_OP;
                        end else begin
`ifdef ALU_OPCODE_CHECK_EN
                            if (is_legal(i_rx_data[NB_OP-1:0])) begin
                                o_alu_op   <= i_rx_data[NB_OP-1:0];
                                o_rx_ready <= 1'b0;
                                state      <= EXEC;
                            end else begin
                                o_error <= 1'b1;
                                o_busy  <= 1'b0;
                                state   <= WAIT_A;
                            end
`else
                            o_alu_op   <= i_rx_data[NB_OP-1:0];
                            o_rx_ready <= 1'b0;
                            state      <= EXEC;
`endif
                        end
                    end else if (timeout_hit) begin
                        // A stalled partial command is dropped; the source restarts from operand A.
                        idle_cnt <= '0;
                        o_busy   <= 1'b0;
                        state    <= WAIT_A;
                    end else if (idle_cnt != CNT_MAX) begin
                        idle_cnt <= idle_cnt + NB_TIMEOUT'(1);
                    end
                end
                EXEC: begin
                    o_tx_data  <= i_alu_result;
                    o_tx_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        o_rx_ready <= 1'b1;
                        o_busy     <= 1'b0;
                        state      <= WAIT_A;
                    end
                end
                default: begin
                    o_tx_valid <= 1'b0;
                    o_rx_ready <= 1'b1;
                    o_busy     <= 1'b0;
                    idle_cnt   <= '0;
                    state      <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and randomized bench for alu_cmd_sequencer, with an ALU stand-in and an arithmetic reference model.
// Checks adapt to whether ALU_OPCODE_CHECK_EN is defined.
module tb_alu_cmd_sequencer;

    localparam int NB_DATA        = 8;
    localparam int NB_OP          = 6;
    localparam int NB_TIMEOUT     = 16;
    localparam int TIMEOUT_CYCLES = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NB_DATA-1:0] rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic [NB_DATA-1:0] alu_a;
    logic [NB_DATA-1:0] alu_b;
    logic [NB_OP-1:0]   alu_op;
    logic [NB_DATA-1:0] alu_result;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic               error;

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer #(
        .NB_DATA        (NB_DATA),
        .NB_OP          (NB_OP),
        .NB_TIMEOUT     (NB_TIMEOUT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_rx_ready   (rx_ready),
        .o_alu_data_a (alu_a),
        .o_alu_data_b (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_result (alu_result),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_busy       (busy),
        .o_error      (error)
    );

    always #5 clk = ~clk;

    // Reference ALU written from the opcode table; unsupported opcodes yield zero.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'd32:   return a + b;
            6'd34:   return a - b;
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd38:   return a ^ b;
            6'd3:    return 8'($signed(a) >>> b);
            6'd2:    return a >> b;
            6'd39:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the byte was taken.
    task automatic send_byte(input logic [7:0] d);
        int n;
        n = 0;
        rx_data  = d;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Entered in the EXEC cycle; holds tx_ready low for 'stall' SEND cycles.
    task automatic finish_cmd(input logic [7:0] exp, input int stall, input string tag);
        check({tag, ":exec_no_valid"}, 32'(tx_valid), 32'd0);
        tx_ready = (stall == 0);
        @(negedge clk);
        check({tag, ":valid"}, 32'(tx_valid), 32'd1);
        check({tag, ":data"}, 32'(tx_data), 32'(exp));
        check({tag, ":no_error"}, 32'(error), 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, ":hold_valid"}, 32'(tx_valid), 32'd1);
            check({tag, ":hold_data"}, 32'(tx_data), 32'(exp));
            check({tag, ":hold_rx_ready"}, 32'(rx_ready), 32'd0);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check({tag, ":valid_drop"}, 32'(tx_valid), 32'd0);
        check({tag, ":idle_busy"}, 32'(busy), 32'd0);
        check({tag, ":idle_rx_ready"}, 32'(rx_ready), 32'd1);
    endtask

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input logic [7:0] exp, input int stall, input string tag);
        send_byte(a);
        send_byte(b);
        send_byte(opb);
        finish_cmd(exp, stall, tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, ":busy"}, 32'(busy), 32'd0);
        check({tag, ":tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, ":error"}, 32'(error), 32'd0);
        check({tag, ":alu_a"}, 32'(alu_a), 32'd0);
        check({tag, ":alu_b"}, 32'(alu_b), 32'd0);
        check({tag, ":alu_op"}, 32'(alu_op), 32'd0);
        check({tag, ":tx_data"}, 32'(tx_data), 32'd0);
    endtask

    initial begin
        logic [5:0] legal_ops [8];
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rop;
        int         rstall;

        legal_ops = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd2, 6'd3, 6'd39};
        rst_n    = 1'b0;
        tx_ready = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_rx_ready", 32'(rx_ready), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);

        // Basic add, result valid for exactly one cycle, operands retained
        run_cmd(8'h05, 8'h03, 8'h20, 8'h08, 0, "add_basic");
        check("retain_a", 32'(alu_a), 32'h05);
        check("retain_b", 32'(alu_b), 32'h03);
        check("retain_op", 32'(alu_op), 32'h20);

        // Subtract with downstream stall; next byte stays pending until SEND completes
        send_byte(8'h03);
        send_byte(8'h05);
        send_byte(8'h22);
        tx_ready = 1'b0;
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        check("stall_exec_rx_ready", 32'(rx_ready), 32'd0);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_data", 32'(tx_data), 32'hFE);
            check("stall_rx_ready", 32'(rx_ready), 32'd0);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check("stall_release_valid", 32'(tx_valid), 32'd0);
        check("stall_release_rx_ready", 32'(rx_ready), 32'd1);
        check("pending_not_taken", 32'(alu_a), 32'h03);
        @(negedge clk);
        check("pending_taken", 32'(alu_a), 32'h77);
        check("pending_busy", 32'(busy), 32'd1);
        rx_valid = 1'b0;
        send_byte(8'h11);
        send_byte(8'h24);
        finish_cmd(8'h11, 0, "and_after_pending");

        // Inter-byte timeout aborts the partial command
        send_byte(8'hAA);
        repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
        check("timeout_not_yet", 32'(busy), 32'd1);
        @(negedge clk);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_rx_ready", 32'(rx_ready), 32'd1);
        check("timeout_no_valid", 32'(tx_valid), 32'd0);
        run_cmd(8'h0F, 8'hF0, 8'h25, 8'hFF, 1, "or_after_timeout");

        // Transfer on the timeout cycle wins
        send_byte(8'h3C);
        repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
        send_byte(8'h04);
        check("edge_transfer_b", 32'(alu_b), 32'h04);
        check("edge_transfer_busy", 32'(busy), 32'd1);
        send_byte(8'h02);
        finish_cmd(8'h03, 0, "srl_edge");

        // Unsupported opcode 0x01
`ifdef ALU_OPCODE_CHECK_EN
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h01);
        check("bad_op_error", 32'(error), 32'd1);
        check("bad_op_busy", 32'(busy), 32'd0);
        check("bad_op_keep_op", 32'(alu_op), 32'h02);
        @(negedge clk);
        check("bad_op_error_drop", 32'(error), 32'd0);
        check("bad_op_no_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("bad_op_still_no_valid", 32'(tx_valid), 32'd0);
`else
        run_cmd(8'h10, 8'h20, 8'h01, alu_ref(8'h10, 8'h20, 6'd1), 0, "unchecked_op");
`endif

        // Reset after operand B
        send_byte(8'h11);
        send_byte(8'h22);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_cmd");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_reset_rx_ready", 32'(rx_ready), 32'd1);
        check("mid_reset_no_valid", 32'(tx_valid), 32'd0);
        run_cmd(8'h80, 8'h01, 8'h02, 8'h40, 0, "srl_after_reset");

        // Reset while holding a result in SEND
        send_byte(8'h55);
        send_byte(8'h0A);
        send_byte(8'h20);
        tx_ready = 1'b0;
        @(negedge clk);
        check("send_before_reset", 32'(tx_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_in_send");
        @(negedge clk);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("send_reset_no_valid", 32'(tx_valid), 32'd0);
        check("send_reset_idle", 32'(busy), 32'd0);

        // Random sweep over all supported opcodes, random upper opcode bits and stalls
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 11; n++) begin
                ra     = 8'($urandom);
                rb     = (legal_ops[k] == 6'd2 || legal_ops[k] == 6'd3) ? 8'($urandom_range(0, 9)) : 8'($urandom);
                rop    = {2'($urandom), legal_ops[k]};
                rstall = int'($urandom_range(0, 3));
                run_cmd(ra, rb, rop, alu_ref(ra, rb, legal_ops[k]), rstall, "random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter NB_DATA, default 8, width of operand, result and stream bytes.
REQ-002 Parameter NB_OP, default 6, width of the ALU opcode.
REQ-003 Parameter NB_TIMEOUT, default 16, width of the inter-byte timeout counter.
REQ-004 Parameter TIMEOUT_CYCLES, default 50000, idle cycles allowed between bytes of one command.
REQ-005 i_clock  in  1  single clock; all state updates on its rising edge.
REQ-006 i_reset  in  1  asynchronous, active-low reset.
REQ-007 i_rx_data  in  NB_DATA  incoming command byte.
REQ-008 i_rx_valid  in  1  i_rx_data valid.
REQ-009 o_rx_ready  out  1  sequencer accepts a byte this cycle.
REQ-010 o_alu_data_a  out  NB_DATA  registered operand A to the ALU.
REQ-011 o_alu_data_b  out  NB_DATA  registered operand B to the ALU.
REQ-012 o_alu_op  out  NB_OP  registered opcode to the ALU.
REQ-013 i_alu_result  in  NB_DATA  combinational ALU result.
REQ-014 o_tx_data  out  NB_DATA  captured result byte.
REQ-015 o_tx_valid  out  1  o_tx_data valid.
REQ-016 i_tx_ready  in  1  downstream accepts o_tx_data.
REQ-017 o_busy  out  1  high in every state except WAIT_A.
REQ-018 o_error  out  1  one-cycle illegal-opcode pulse (see Configuration).

Function
REQ-019 A byte SHALL transfer only in a cycle where i_rx_valid and o_rx_ready are both high.
REQ-020 States SHALL be WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND; o_rx_ready high only in WAIT_A, WAIT_B, WAIT_OP.
REQ-021 WAIT_A: transfer loads o_alu_data_a, goes to WAIT_B.
REQ-022 WAIT_B: transfer loads o_alu_data_b, goes to WAIT_OP.
REQ-023 WAIT_OP: transfer loads o_alu_op from i_rx_data[NB_OP-1:0] (upper bits ignored), goes to EXEC.
REQ-024 EXEC SHALL last exactly one cycle, capture i_alu_result into o_tx_data, and go to SEND.
REQ-025 o_tx_valid SHALL assert the cycle after EXEC, i.e. two cycles after the opcode transfer.
REQ-026 SEND: o_tx_data and o_tx_valid SHALL hold stable until i_tx_ready high; on that edge deassert o_tx_valid and go to WAIT_A.
REQ-027 Incoming bytes during EXEC/SEND SHALL not be accepted and SHALL remain pending for the source.
REQ-028 Operand/opcode registers SHALL retain values after a command until overwritten by the next one.
REQ-029 In WAIT_B/WAIT_OP a counter SHALL increment each cycle without transfer and clear on transfer or state change.
REQ-030 When the counter reaches TIMEOUT_CYCLES-1 the FSM SHALL return to WAIT_A, discard the partial command, and emit no result.
REQ-031 A transfer in the same cycle as timeout SHALL win: the byte is accepted, no abort.
REQ-032 Counter SHALL saturate, never wrap.

Reset
REQ-033 Reset low SHALL immediately force WAIT_A, clear all registers and counter, regardless of state.
REQ-034 Reset values: o_rx_ready 0 during reset, 1 first cycle after release; o_alu_data_a/b, o_alu_op, o_tx_data 0; o_tx_valid, o_busy, o_error 0.
REQ-035 Reset mid-command or in SEND SHALL drop the command without emitting a result.

Configuration
REQ-036 Macro ALU_OPCODE_CHECK_EN defined: opcodes outside {32,34,36,37,38,2,3,39} at WAIT_OP SHALL pulse o_error one cycle, skip EXEC/SEND, return to WAIT_A; o_alu_op keeps its previous value.
REQ-037 Macro not defined: every opcode SHALL be executed and o_error SHALL be tied to 0.

Verification
REQ-038 Bytes 0x05, 0x03, 0x20, tx_ready high -> o_tx_data 0x08, o_tx_valid high exactly 2 cycles after op transfer, for one cycle.
REQ-039 Bytes 0x03, 0x05, 0x22, tx_ready low for 5 cycles -> o_tx_data 0xFE held stable, o_rx_ready low throughout, one transfer on release.
REQ-040 Byte 0xAA then silence TIMEOUT_CYCLES (set 8) -> WAIT_A, o_busy low; next 0x0F, 0xF0, 0x25 -> o_tx_data 0xFF.
REQ-041 With ALU_OPCODE_CHECK_EN: 0x10, 0x20, 0x01 -> o_error one-cycle pulse, no o_tx_valid; without macro -> result emitted, o_error 0.
REQ-042 Reset asserted after operand B accepted -> all outputs 0 asynchronously; after release 0x80, 0x01, 0x02 -> o_tx_data 0x40.
REQ-043 Random sweep of all eight legal opcodes, 11 commands each, checks o_tx_data against +, -, &, |, ^, >>>, >>, ~| reference.
